// File: rtl/register_file_sb.sv
// -----------------------------------------------------------------------------
// register_file_sb
//   Integer register file with a per-register busy scoreboard. It has
//   NUM_READ combinational read ports and one synchronous write port.
//   Register 0 always reads as zero and cannot be written or marked busy.
//   A busy bit is set when an instruction issues to that register. It is
//   cleared when the result is written back, and all busy bits are cleared
//   by a pipeline flush. Each read port reports a hazard when its register
//   is busy.
//
//   Optional feature (macro REGFILE_BYPASS_EN):
//     When defined, a same-cycle writeback to a register that is being read
//     is forwarded to that read port (write-first). The hazard flag for that
//     port is then cleared.
//
// Ports
//   clk_i         core clock, rising edge
//   rst_n_i       asynchronous active-low reset
//   we_i          writeback strobe (write rd_i, clear busy of rd_addr_i)
//   rd_addr_i     writeback destination
//   rd_i          writeback data
//   issue_i       mark issue_addr_i busy
//   issue_addr_i  destination of the issuing instruction
//   flush_i       clear every busy bit
//   rs_addr_i     packed read addresses, port p = [p*AW +: AW]
//   rs_data_o     packed read data, same order
//   hazard_o      per-port pending flag
//   busy_cnt_o    registered count of busy registers
// -----------------------------------------------------------------------------
module register_file_sb #(
    parameter  int DATA_WIDTH   = 32,
    parameter  int NUM_REGISTER = 32,
    parameter  int NUM_READ     = 2,
    localparam int AW           = $clog2(NUM_REGISTER)
) (
    input  logic                           clk_i,
    input  logic                           rst_n_i,
    input  logic                           we_i,
    input  logic [AW-1:0]                  rd_addr_i,
    input  logic [DATA_WIDTH-1:0]          rd_i,
    input  logic                           issue_i,
    input  logic [AW-1:0]                  issue_addr_i,
    input  logic                           flush_i,
    input  logic [NUM_READ*AW-1:0]         rs_addr_i,
    output logic [NUM_READ*DATA_WIDTH-1:0] rs_data_o,
    output logic [NUM_READ-1:0]            hazard_o,
    output logic [AW:0]                    busy_cnt_o
);

    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0]   regs_q [NUM_REGISTER];
    logic [NUM_REGISTER-1:0] busy_q, busy_d;
    logic [CW-1:0]           busy_cnt_q, busy_cnt_d;

    // Register storage. Entry 0 is never written, so it stays at its reset value of zero.
    // NOTE: the whole array is reset because reset must leave every register reading 0.
    // That requirement stops this array from mapping onto a RAM macro.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < NUM_REGISTER; i++) regs_q[i] <= '0;
        end else begin
            for (int i = 1; i < NUM_REGISTER; i++) begin
                // NOTE: state is updated with non-blocking assignments.
                // All flops then sample pre-edge values, with no ordering races.
                if (we_i && rd_addr_i == AW'(i)) regs_q[i] <= rd_i;
            end
        end
    end

    // Scoreboard next state. Later assignments take priority: a new issue beats a
    // writeback to the same register, and flush overrides both.
    always_comb begin
        // NOTE: defaulting to the held value first keeps this block free of latches.
        busy_d = busy_q;
        if (flush_i) begin
            busy_d = '0;
        end else begin
            if (we_i)    busy_d[rd_addr_i]    = 1'b0;
            if (issue_i) busy_d[issue_addr_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // The count is computed from the next state so that it changes on the same edge as the bits.
    always_comb begin
        busy_cnt_d = '0;
        for (int i = 0; i < NUM_REGISTER; i++) busy_cnt_d = busy_cnt_d + CW'(busy_d[i]);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign busy_cnt_o = busy_cnt_q;

    // Read ports. busy_q[0] is always 0, so port reads of x0 never raise a hazard.
    for (genvar p = 0; p < NUM_READ; p++) begin : g_read
        logic [AW-1:0]         addr;
        logic [DATA_WIDTH-1:0] data;
        logic                  haz;

        assign addr = rs_addr_i[p*AW +: AW];

        always_comb begin
            data = (addr == '0) ? '0 : regs_q[addr];
            haz  = busy_q[addr];
`ifdef REGFILE_BYPASS_EN
            // Forward the writeback data on an address match, and drop the hazard it resolves.
            if (we_i && rd_addr_i != '0 && addr == rd_addr_i) begin
                data = rd_i;
                haz  = 1'b0;
            end
`endif
        end

        assign rs_data_o[p*DATA_WIDTH +: DATA_WIDTH] = data;
        assign hazard_o[p]                           = haz;
    end

endmodule

// File: tb/tb_register_file_sb.sv
module tb_register_file_sb;

    localparam int DW = 32;
    localparam int NR = 32;
    localparam int AW = 5;

    logic          clk_i = 1'b0;
    logic          rst_n_i;
    logic          we_i;
    logic [AW-1:0] rd_addr_i;
    logic [DW-1:0] rd_i;
    logic          issue_i;
    logic [AW-1:0] issue_addr_i;
    logic          flush_i;
    logic [2*AW-1:0] rs_addr_i;
    logic [2*DW-1:0] rs_data_o;
    logic [1:0]      hazard_o;
    logic [AW:0]     busy_cnt_o;

    register_file_sb #(.DATA_WIDTH(DW), .NUM_REGISTER(NR), .NUM_READ(2)) dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .we_i         (we_i),
        .rd_addr_i    (rd_addr_i),
        .rd_i         (rd_i),
        .issue_i      (issue_i),
        .issue_addr_i (issue_addr_i),
        .flush_i      (flush_i),
        .rs_addr_i    (rs_addr_i),
        .rs_data_o    (rs_data_o),
        .hazard_o     (hazard_o),
        .busy_cnt_o   (busy_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: architectural register contents plus the set of pending registers.
    logic [DW-1:0] m_reg [NR];
    logic [NR-1:0] m_busy;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR; i++) m_reg[i] = '0;
        m_busy = '0;
    endtask

    function automatic logic bypass_hit(input logic [AW-1:0] a);
`ifdef REGFILE_BYPASS_EN
        return we_i && rd_addr_i != 0 && a == rd_addr_i;
`else
        return 1'b0;
`endif
    endfunction

    // Compare every output against the model for the inputs currently applied.
    task automatic check_model();
        for (int p = 0; p < 2; p++) begin
            logic [AW-1:0] a;
            logic [DW-1:0] exp_d;
            logic          exp_h;
            a     = rs_addr_i[p*AW +: AW];
            exp_d = (a == 0) ? '0 : (bypass_hit(a) ? rd_i : m_reg[a]);
            exp_h = (a != 0) && m_busy[a] && !bypass_hit(a);
            check($sformatf("data p%0d a%0d", p, a), rs_data_o[p*DW +: DW], exp_d);
            check($sformatf("hazard p%0d a%0d", p, a), DW'(hazard_o[p]), DW'(exp_h));
        end
        check("busy_cnt", DW'(busy_cnt_o), DW'($countones(m_busy)));
    endtask

    // Drive one cycle's inputs after the falling edge, then check the settled outputs.
    task automatic apply(input logic we, input logic [AW-1:0] rd, input logic [DW-1:0] data,
                         input logic iss, input logic [AW-1:0] ia, input logic fl,
                         input logic [AW-1:0] rs0, input logic [AW-1:0] rs1);
        @(negedge clk_i);
        we_i = we; rd_addr_i = rd; rd_i = data;
        issue_i = iss; issue_addr_i = ia; flush_i = fl;
        rs_addr_i = {rs1, rs0};
        #1;
        check_model();
    endtask

    // Advance the model across the rising edge using the inputs that are held there.
    task automatic commit();
        logic [NR-1:0] nb;
        nb = m_busy;
        if (flush_i) nb = '0;
        else begin
            if (we_i)    nb[rd_addr_i]    = 1'b0;
            if (issue_i) nb[issue_addr_i] = 1'b1;
        end
        nb[0] = 1'b0;
        if (we_i && rd_addr_i != 0) m_reg[rd_addr_i] = rd_i;
        @(posedge clk_i);
        m_busy = nb;
    endtask

    task automatic peek(input logic [AW-1:0] rs0, input logic [AW-1:0] rs1);
        apply(0, 0, 0, 0, 0, 0, rs0, rs1);
    endtask

    initial begin
        rst_n_i = 1'b0;
        we_i = 0; rd_addr_i = 0; rd_i = 0; issue_i = 0; issue_addr_i = 0; flush_i = 0; rs_addr_i = 0;
        model_reset();

        // Reset state across every address on both ports.
        for (int a = 0; a < NR; a++) begin
            rs_addr_i = {AW'(NR - 1 - a), AW'(a)};
            #1;
            check("rst data0", rs_data_o[DW-1:0], '0);
            check("rst data1", rs_data_o[2*DW-1:DW], '0);
            check("rst hazard", DW'(hazard_o), '0);
            check("rst cnt", DW'(busy_cnt_o), '0);
        end
        @(negedge clk_i);
        rst_n_i = 1'b1;

        // Write then read x31.
        apply(1, 31, 32'hFFFF_FFFF, 0, 0, 0, 31, 0); commit();
        peek(31, 0);
        check("x31 read", rs_data_o[DW-1:0], 32'hFFFF_FFFF);
        check("x0 read", rs_data_o[2*DW-1:DW], 32'h0);
        commit();

        // x0 protection against both writes and issues.
        apply(1, 0, 32'hDEAD_BEEF, 1, 0, 0, 0, 0); commit();
        peek(0, 0);
        check("x0 data", rs_data_o[DW-1:0], 32'h0);
        check("x0 cnt", DW'(busy_cnt_o), 0);
        commit();

        // Issue x5, then write it back.
        apply(0, 0, 0, 1, 5, 0, 5, 0); commit();
        peek(5, 0);
        check("x5 hazard", DW'(hazard_o), 1);
        check("x5 cnt", DW'(busy_cnt_o), 1);
        commit();
        apply(1, 5, 32'h1234, 0, 0, 0, 0, 0); commit();
        peek(5, 5);
        check("x5 wb hazard", DW'(hazard_o), 0);
        check("x5 wb cnt", DW'(busy_cnt_o), 0);
        check("x5 wb data", rs_data_o[DW-1:0], 32'h1234);
        commit();

        // Issue and writeback of x7 in the same cycle: issue wins.
        apply(1, 7, 32'h77, 1, 7, 0, 0, 0); commit();
        peek(7, 7);
        check("x7 hazard", DW'(hazard_o), 3);
        check("x7 cnt", DW'(busy_cnt_o), 1);
        commit();

        // Issue x1..x3 with flush on the third issue.
        apply(0, 0, 0, 1, 1, 0, 1, 2); commit();
        apply(0, 0, 0, 1, 2, 0, 1, 2); commit();
        apply(0, 0, 0, 1, 3, 1, 3, 7); commit();
        peek(3, 7);
        check("flush cnt", DW'(busy_cnt_o), 0);
        check("flush hazard", DW'(hazard_o), 0);
        commit();

        // Write to busy x9 while reading it.
        apply(0, 0, 0, 1, 9, 0, 9, 9); commit();
        apply(1, 9, 32'hAA, 0, 0, 0, 9, 9);
`ifdef REGFILE_BYPASS_EN
        check("byp data", rs_data_o[DW-1:0], 32'hAA);
        check("byp hazard", DW'(hazard_o), 0);
`else
        check("byp data", rs_data_o[DW-1:0], 32'h0);
        check("byp hazard", DW'(hazard_o), 3);
`endif
        commit();
        peek(9, 9);
        check("x9 after data", rs_data_o[DW-1:0], 32'hAA);
        check("x9 after hazard", DW'(hazard_o), 0);
        commit();

        // Randomized traffic, with one asynchronous reset in the middle.
        for (int n = 0; n < 600; n++) begin
            logic [AW-1:0] rd, rs0, rs1;
            rd  = AW'($urandom_range(0, NR - 1));
            rs0 = ($urandom_range(0, 3) == 0) ? rd : AW'($urandom_range(0, NR - 1));
            rs1 = ($urandom_range(0, 3) == 0) ? rd : AW'($urandom_range(0, NR - 1));
            apply(1'($urandom_range(0, 1)), rd, $urandom, 1'($urandom_range(0, 1)),
                  AW'($urandom_range(0, NR - 1)), ($urandom_range(0, 15) == 0), rs0, rs1);
            commit();
            if (n == 300) begin
                @(negedge clk_i);
                #2 rst_n_i = 1'b0;
                #1;
                model_reset();
                check("midrst data", rs_data_o[DW-1:0] | rs_data_o[2*DW-1:DW], '0);
                check("midrst hazard", DW'(hazard_o), '0);
                check("midrst cnt", DW'(busy_cnt_o), '0);
                @(negedge clk_i);
                rst_n_i = 1'b1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
